// File: rtl/spu_decode.sv
// SPU decode stage: classifies the fetched instruction pair to the even/odd
// pipes, detects dual-issue hazards and issues one or both instructions.
module spu_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] instr_d [0:1],
  input  logic [7:0]  pc,
  output logic [7:0]  pc_wb,
  output logic        stall,
  output logic [0:31] even_instr,
  output logic        even_valid,
  output logic [0:31] odd_instr,
  output logic        odd_valid
);

  typedef enum logic [1:0] {
    PIPE_NONE = 2'd0,
    PIPE_EVEN = 2'd1,
    PIPE_ODD  = 2'd2
  } pipe_e;

  typedef struct packed {
    pipe_e      pipe;
    logic       wr_en;
    logic [6:0] wr_reg;
    logic [2:0] rd_en;
    logic [6:0] rd_reg0;
    logic [6:0] rd_reg1;
    logic [6:0] rd_reg2;
  } dec_t;

  localparam logic [0:10] OP_A    = 11'b00011000000;
  localparam logic [0:10] OP_AH   = 11'b00011001000;
  localparam logic [0:10] OP_FA   = 11'b01011000100;
  localparam logic [0:10] OP_NOP  = 11'b01000000001;
  localparam logic [0:10] OP_LNOP = 11'b00000000001;
  localparam logic [0:8]  OP_IL   = 9'b010000001;
  localparam logic [0:8]  OP_BR   = 9'b001100100;
  localparam logic [0:7]  OP_LQD  = 8'b00110100;
  localparam logic [0:7]  OP_STQD = 8'b00100100;
  localparam logic [0:3]  OP_MPYA = 4'b1100;
  localparam logic [0:3]  OP_FMA  = 4'b1110;
  localparam logic [0:3]  OP_SHUFB = 4'b1011;

  // Opcodes are matched longest format first so short RRR opcodes never
  // shadow an 11-bit RR opcode that shares their leading bits.
  function automatic dec_t decode(input logic [0:31] w);
    dec_t d;
    d      = '0;
    d.pipe = PIPE_EVEN;
    if (w == 32'h0000_0000) begin
      d.pipe = PIPE_NONE;
    end else if (w[0:10] == OP_A || w[0:10] == OP_AH || w[0:10] == OP_FA) begin
      d.wr_en   = 1'b1;
      d.wr_reg  = w[25:31];
      d.rd_en   = 3'b011;
      d.rd_reg0 = w[18:24];
      d.rd_reg1 = w[11:17];
    end else if (w[0:10] == OP_NOP) begin
      d.pipe = PIPE_EVEN;
    end else if (w[0:10] == OP_LNOP) begin
      d.pipe = PIPE_ODD;
    end else if (w[0:8] == OP_IL) begin
      d.wr_en  = 1'b1;
      d.wr_reg = w[25:31];
    end else if (w[0:8] == OP_BR) begin
      d.pipe = PIPE_ODD;
    end else if (w[0:7] == OP_LQD) begin
      d.pipe    = PIPE_ODD;
      d.wr_en   = 1'b1;
      d.wr_reg  = w[25:31];
      d.rd_en   = 3'b001;
      d.rd_reg0 = w[18:24];
    end else if (w[0:7] == OP_STQD) begin
      d.pipe    = PIPE_ODD;
      d.rd_en   = 3'b011;
      d.rd_reg0 = w[18:24];
      d.rd_reg1 = w[25:31];
    end else if (w[0:3] == OP_MPYA || w[0:3] == OP_FMA || w[0:3] == OP_SHUFB) begin
      d.pipe    = (w[0:3] == OP_SHUFB) ? PIPE_ODD : PIPE_EVEN;
      d.wr_en   = 1'b1;
      d.wr_reg  = w[4:10];
      d.rd_en   = 3'b111;
      d.rd_reg0 = w[18:24];
      d.rd_reg1 = w[11:17];
      d.rd_reg2 = w[25:31];
    end
    return d;
  endfunction

  dec_t        dec0;
  dec_t        dec1;
  logic        raw;
  logic        conflict;
  logic [0:31] even_nxt;
  logic        even_v_nxt;
  logic [0:31] odd_nxt;
  logic        odd_v_nxt;

  assign dec0 = decode(instr_d[0]);
  assign dec1 = decode(instr_d[1]);

  assign raw = dec0.wr_en &&
               ((dec1.rd_en[0] && dec1.rd_reg0 == dec0.wr_reg) ||
                (dec1.rd_en[1] && dec1.rd_reg1 == dec0.wr_reg) ||
                (dec1.rd_en[2] && dec1.rd_reg2 == dec0.wr_reg));

  assign conflict = (dec0.pipe != PIPE_NONE) && (dec1.pipe != PIPE_NONE) &&
                    ((dec0.pipe == dec1.pipe) || raw);

  assign stall = reset && conflict;
  assign pc_wb = stall ? pc - 8'd1 : pc;

  // Without a conflict the two slots always target different pipes, so the
  // slot-1 routing can never overwrite slot 0.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    even_nxt   = '0;
    even_v_nxt = 1'b0;
    odd_nxt    = '0;
    odd_v_nxt  = 1'b0;
    if (dec0.pipe == PIPE_EVEN) begin
      even_nxt   = instr_d[0];
      even_v_nxt = 1'b1;
    end else if (dec0.pipe == PIPE_ODD) begin
      odd_nxt   = instr_d[0];
      odd_v_nxt = 1'b1;
    end
    if (!conflict) begin
      if (dec1.pipe == PIPE_EVEN) begin
        even_nxt   = instr_d[1];
        even_v_nxt = 1'b1;
      end else if (dec1.pipe == PIPE_ODD) begin
        odd_nxt   = instr_d[1];
        odd_v_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      even_instr <= '0;
      even_valid <= 1'b0;
      odd_instr  <= '0;
      odd_valid  <= 1'b0;
    end else begin
      even_instr <= even_nxt;
      even_valid <= even_v_nxt;
      odd_instr  <= odd_nxt;
      odd_valid  <= odd_v_nxt;
    end
  end

endmodule

// File: tb/tb_spu_decode.sv
// Self-checking bench for spu_decode: vector table for pair decode plus
// hand-written reset, async-reset and resume sequences.
module tb_spu_decode;

  logic        clk;
  logic        reset;
  logic [0:31] instr_d [0:1];
  logic [7:0]  pc;
  logic [7:0]  pc_wb;
  logic        stall;
  logic [0:31] even_instr;
  logic        even_valid;
  logic [0:31] odd_instr;
  logic        odd_valid;

  spu_decode dut (
    .clk        (clk),
    .reset      (reset),
    .instr_d    (instr_d),
    .pc         (pc),
    .pc_wb      (pc_wb),
    .stall      (stall),
    .even_instr (even_instr),
    .even_valid (even_valid),
    .odd_instr  (odd_instr),
    .odd_valid  (odd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_A     = 32'h1800_8083; // a $3,$1,$2
  localparam logic [31:0] I_A7    = 32'h1800_8087; // a $7,$1,$2
  localparam logic [31:0] I_LQD   = 32'h3400_0284; // lqd $4 <- ($5)
  localparam logic [31:0] I_STQD  = 32'h2400_0283; // stqd $3 -> ($5)
  localparam logic [31:0] I_IL    = 32'h4080_0003; // il $3,0
  localparam logic [31:0] I_BR    = 32'h3200_0000;
  localparam logic [31:0] I_NOP   = 32'h4020_0000;
  localparam logic [31:0] I_LNOP  = 32'h0020_0000;
  localparam logic [31:0] I_SHUFB = 32'hB120_4083; // shufb $9,$1,$1,$3
  localparam logic [31:0] I_UNK   = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [7:0]  pc;
    logic        stall;
    logic [7:0]  pc_wb;
    logic [31:0] even_i;
    logic        even_v;
    logic [31:0] odd_i;
    logic        odd_v;
  } vec_t;

  typedef struct {
    logic [31:0] even_i;
    logic        even_v;
    logic [31:0] odd_i;
    logic        odd_v;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty when output was due", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " even_instr"}, even_instr, e.even_i);
      check({tag, " even_valid"}, {31'd0, even_valid}, {31'd0, e.even_v});
      check({tag, " odd_instr"},  odd_instr,  e.odd_i);
      check({tag, " odd_valid"},  {31'd0, odd_valid},  {31'd0, e.odd_v});
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    instr_d[0] = v.i0;
    instr_d[1] = v.i1;
    pc         = v.pc;
    #1;
    check({tag, " stall"}, {31'd0, stall}, {31'd0, v.stall});
    check({tag, " pc_wb"}, {24'd0, pc_wb}, {24'd0, v.pc_wb});
    sb.push_back('{v.even_i, v.even_v, v.odd_i, v.odd_v});
    @(posedge clk);
    #1;
    check_issue(tag);
  endtask

  vec_t vecs [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{I_LQD,   I_A,     8'd10,  1'b0, 8'd10,  I_A,     1'b1, I_LQD,   1'b1},
      '{I_A,     I_A7,    8'd20,  1'b1, 8'd19,  I_A,     1'b1, 32'h0,   1'b0},
      '{32'h0,   32'h0,   8'd19,  1'b0, 8'd19,  32'h0,   1'b0, 32'h0,   1'b0},
      '{I_A,     I_STQD,  8'd40,  1'b1, 8'd39,  I_A,     1'b1, 32'h0,   1'b0},
      '{32'h0,   32'h0,   8'd39,  1'b0, 8'd39,  32'h0,   1'b0, 32'h0,   1'b0},
      '{32'h0,   32'h0,   8'd41,  1'b0, 8'd41,  32'h0,   1'b0, 32'h0,   1'b0},
      '{I_A,     I_LQD,   8'd42,  1'b0, 8'd42,  I_A,     1'b1, I_LQD,   1'b1},
      '{I_IL,    I_BR,    8'd60,  1'b0, 8'd60,  I_IL,    1'b1, I_BR,    1'b1},
      '{I_NOP,   I_LNOP,  8'd61,  1'b0, 8'd61,  I_NOP,   1'b1, I_LNOP,  1'b1},
      '{I_LNOP,  I_LNOP,  8'd5,   1'b1, 8'd4,   32'h0,   1'b0, I_LNOP,  1'b1},
      '{I_A,     I_SHUFB, 8'd50,  1'b1, 8'd49,  I_A,     1'b1, 32'h0,   1'b0},
      '{I_SHUFB, I_A,     8'd70,  1'b0, 8'd70,  I_A,     1'b1, I_SHUFB, 1'b1},
      '{I_STQD,  I_A,     8'd80,  1'b0, 8'd80,  I_A,     1'b1, I_STQD,  1'b1},
      '{32'h0,   I_A,     8'd90,  1'b0, 8'd90,  I_A,     1'b1, 32'h0,   1'b0},
      '{I_LQD,   32'h0,   8'd91,  1'b0, 8'd91,  32'h0,   1'b0, I_LQD,   1'b1},
      '{I_UNK,   I_A,     8'd100, 1'b1, 8'd99,  I_UNK,   1'b1, 32'h0,   1'b0},
      '{I_A,     I_A7,    8'd0,   1'b1, 8'hFF,  I_A,     1'b1, 32'h0,   1'b0}
    };

    // Reset held with a legal pair presented: nothing issues.
    reset      = 1'b0;
    instr_d[0] = I_A;
    instr_d[1] = I_LQD;
    pc         = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    check("rst even_instr", even_instr, 32'h0);
    check("rst even_valid", {31'd0, even_valid}, 32'h0);
    check("rst odd_instr",  odd_instr,  32'h0);
    check("rst odd_valid",  {31'd0, odd_valid},  32'h0);
    check("rst stall",      {31'd0, stall},      32'h0);
    check("rst pc_wb",      {24'd0, pc_wb},      32'd7);

    // First edge after release issues the pair.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel stall", {31'd0, stall}, 32'h0);
    sb.push_back('{I_A, 1'b1, I_LQD, 1'b1});
    @(posedge clk);
    #1;
    check_issue("rel");

    for (int i = 0; i < 17; i++) apply(vecs[i], i);

    // Async reset between edges clears in-flight issue immediately.
    apply('{I_IL, I_BR, 8'd120, 1'b0, 8'd120, I_IL, 1'b1, I_BR, 1'b1}, 100);
    instr_d[0] = I_A;
    instr_d[1] = I_A7;
    #2;
    reset = 1'b0;
    #1;
    check("arst even_valid", {31'd0, even_valid}, 32'h0);
    check("arst even_instr", even_instr, 32'h0);
    check("arst odd_valid",  {31'd0, odd_valid},  32'h0);
    check("arst odd_instr",  odd_instr,  32'h0);
    check("arst stall",      {31'd0, stall},      32'h0);
    check("arst pc_wb",      {24'd0, pc_wb},      32'd120);
    @(posedge clk);
    #1;
    check("arst hold even_valid", {31'd0, even_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply('{I_A, I_LQD, 8'd130, 1'b0, 8'd130, I_A, 1'b1, I_LQD, 1'b1}, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
